// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared types and constants for the ALU datapath blocks.
//   - mm_state_t    : state encoding for minmax_tracker
//   - DEFAULT_WIDTH : default operand width of the datapath
//   - sat_inc       : saturating counter increment helper
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } mm_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Saturating increment for an 8-bit container. The caller passes the
    // all-ones limit of its own counter width, so narrower counters hold
    // at their own maximum.
    function automatic logic [7:0] sat_inc(input logic [7:0] value, input logic [7:0] limit);
        return (value == limit) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/comparator.sv
// -----------------------------------------------------------------------------
// comparator
//   Unsigned magnitude comparator.
//   Ports:
//     a, b          : SIZE-bit unsigned operands
//     is_a_greater  : a > b
//     is_equal      : a == b
// -----------------------------------------------------------------------------
module comparator #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            is_a_greater,
    output logic            is_equal
);

    assign is_a_greater = (a > b);
    assign is_equal     = (a == b);

endmodule

// File: rtl/minmax_tracker.sv
// -----------------------------------------------------------------------------
// minmax_tracker
//   Streaming stage that accepts a burst of unsigned samples and reports the
//   running minimum, maximum, saturating sample count and an all-equal flag as
//   a single result beat once the burst's last sample has been accepted.
//   Upstream is stalled (in_ready=0) while the result beat is pending.
//   Ports:
//     clk, rst_n            : clock, synchronous active-low reset
//     in_valid/in_ready     : sample handshake
//     in_data, in_last      : sample and end-of-burst marker
//     out_valid/out_ready   : result handshake
//     out_min, out_max      : extremes of the burst
//     out_count             : samples accepted, saturating at all-ones
//     out_all_equal         : every sample in the burst was identical
// -----------------------------------------------------------------------------
module minmax_tracker
    import alu_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_min,
    output logic [WIDTH-1:0]   out_max,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_all_equal
);

    mm_state_t          state, state_next;
    logic [WIDTH-1:0]   min_q, max_q;
    logic [COUNT_W-1:0] count_q;
    logic               all_equal_q;

    logic accept, handoff;
    logic new_is_max, new_eq_max;
    logic new_is_min, new_eq_min;

    // new sample vs. current max: update max when the sample is strictly larger
    comparator #(.SIZE(WIDTH)) cmp_max (
        .a            (in_data),
        .b            (max_q),
        .is_a_greater (new_is_max),
        .is_equal     (new_eq_max)
    );

    // current min vs. new sample: update min when the sample is strictly smaller
    comparator #(.SIZE(WIDTH)) cmp_min (
        .a            (min_q),
        .b            (in_data),
        .is_a_greater (new_is_min),
        .is_equal     (new_eq_min)
    );

    assign accept  = in_valid && in_ready;
    assign handoff = out_valid && out_ready;

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_next = state;
        in_ready   = 1'b1;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept && in_last) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                if (handoff) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            min_q       <= '0;
            max_q       <= '0;
            count_q     <= '0;
            all_equal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept && (state == ST_IDLE)) begin
                // first sample of a burst seeds both extremes
                min_q       <= in_data;
                max_q       <= in_data;
                count_q     <= COUNT_W'(1);
                all_equal_q <= 1'b1;
            end else if (accept && (state == ST_ACCUM)) begin
                // ties compare not-greater on both sides, so they leave min/max untouched
                if (new_is_max) begin
                    max_q <= in_data;
                end
                if (new_is_min) begin
                    min_q <= in_data;
                end
                if (count_q != {COUNT_W{1'b1}}) begin
                    count_q <= count_q + COUNT_W'(1);
                end
                // once min==max, a sample keeps them equal only if it matches both;
                // this tracks (min==max) without a third comparator
                all_equal_q <= all_equal_q && new_eq_max && new_eq_min;
            end
        end
    end

    assign out_min       = min_q;
    assign out_max       = max_q;
    assign out_count     = count_q;
    assign out_all_equal = all_equal_q;

endmodule

// File: tb/tb_minmax_tracker.sv
// -----------------------------------------------------------------------------
// tb_minmax_tracker
//   Drives two trackers with identical stimulus: dut_a with the default
//   COUNT_W=8 and dut_b with COUNT_W=2 for saturation. Expected result beats
//   are pushed into per-DUT queues when a burst is issued; independent monitors
//   compare the presented beat against the queue head every cycle it is valid
//   (which also covers output stability while stalled) and pop on handoff.
// -----------------------------------------------------------------------------
module tb_minmax_tracker;

    typedef struct packed {
        logic [7:0] mn;
        logic [7:0] mx;
        logic [7:0] cnt;
        logic       eq;
    } exp_t;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_last   = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_data   = 8'h00;

    logic       a_in_ready, a_out_valid, a_all_equal;
    logic [7:0] a_min, a_max, a_count;
    logic       b_in_ready, b_out_valid, b_all_equal;
    logic [7:0] b_min, b_max;
    logic [1:0] b_count;

    int checks   = 0;
    int failures = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    minmax_tracker #(.WIDTH(8), .COUNT_W(8)) dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (a_in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (a_out_valid),
        .out_ready     (out_ready),
        .out_min       (a_min),
        .out_max       (a_max),
        .out_count     (a_count),
        .out_all_equal (a_all_equal)
    );

    minmax_tracker #(.WIDTH(8), .COUNT_W(2)) dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (b_in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .out_valid     (b_out_valid),
        .out_ready     (out_ready),
        .out_min       (b_min),
        .out_max       (b_max),
        .out_count     (b_count),
        .out_all_equal (b_all_equal)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // expected beat for both DUTs; dut_b's 2-bit counter saturates at 3
    task automatic expect_beat(input logic [7:0] mn, input logic [7:0] mx, input int cnt, input logic eq);
        q_a.push_back('{mn: mn, mx: mx, cnt: 8'(cnt), eq: eq});
        q_b.push_back('{mn: mn, mx: mx, cnt: (cnt > 3) ? 8'd3 : 8'(cnt), eq: eq});
    endtask

    // call just after a rising edge; returns just after the accepting edge
    task automatic send(input logic [7:0] d, input logic last);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = a_in_ready;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    // last sample: result must be presented the very next cycle
    task automatic send_last(input logic [7:0] d);
        send(d, 1'b1);
        check("latency_a_out_valid", 32'(a_out_valid), 32'd1);
        check("latency_b_out_valid", 32'(b_out_valid), 32'd1);
        check("hold_a_in_ready", 32'(a_in_ready), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && a_out_valid) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat_a: got out_valid=1, expected no beat (t=%0t)", $time);
            end else begin
                check("a_min",       32'(a_min),       32'(q_a[0].mn));
                check("a_max",       32'(a_max),       32'(q_a[0].mx));
                check("a_count",     32'(a_count),     32'(q_a[0].cnt));
                check("a_all_equal", 32'(a_all_equal), 32'(q_a[0].eq));
                if (out_ready) void'(q_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat_b: got out_valid=1, expected no beat (t=%0t)", $time);
            end else begin
                check("b_min",       32'(b_min),       32'(q_b[0].mn));
                check("b_max",       32'(b_max),       32'(q_b[0].mx));
                check("b_count",     32'(b_count),     32'(q_b[0].cnt));
                check("b_all_equal", 32'(b_all_equal), 32'(q_b[0].eq));
                if (out_ready) void'(q_b.pop_front());
            end
        end
    end

    initial begin
        // reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_a_in_ready",  32'(a_in_ready),  32'd1);
        check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_a_min",       32'(a_min),       32'd0);
        check("rst_a_max",       32'(a_max),       32'd0);
        check("rst_a_count",     32'(a_count),     32'd0);
        check("rst_a_all_equal", 32'(a_all_equal), 32'd0);
        check("rst_b_in_ready",  32'(b_in_ready),  32'd1);
        check("rst_b_out_valid", 32'(b_out_valid), 32'd0);

        // mixed burst
        expect_beat(8'h05, 8'hF0, 3, 1'b0);
        send(8'h12, 1'b0);
        send(8'hF0, 1'b0);
        send_last(8'h05);

        // single-sample burst from IDLE
        expect_beat(8'h7A, 8'h7A, 1, 1'b1);
        send_last(8'h7A);

        // all-equal burst with downstream back-pressure
        expect_beat(8'h33, 8'h33, 3, 1'b1);
        send(8'h33, 1'b0);
        send(8'h33, 1'b0);
        out_ready = 1'b0;
        send_last(8'h33);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_a_in_ready",  32'(a_in_ready),  32'd0);
            check("stall_b_out_valid", 32'(b_out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_handoff_a_in_ready",  32'(a_in_ready),  32'd1);
        check("post_handoff_a_out_valid", 32'(a_out_valid), 32'd0);
        check("post_handoff_b_in_ready",  32'(b_in_ready),  32'd1);

        // upstream stalls mid-burst, extremes at both ends of the range
        expect_beat(8'h00, 8'hFF, 3, 1'b0);
        send(8'h80, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        send(8'h00, 1'b0);
        send_last(8'hFF);

        // five samples: dut_b saturates its count at 3
        expect_beat(8'h00, 8'h04, 5, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send_last(8'h00);

        // reset mid-burst discards it
        send(8'h40, 1'b0);
        send(8'h41, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_a_out_valid", 32'(a_out_valid), 32'd0);
        check("midrst_a_in_ready",  32'(a_in_ready),  32'd1);
        check("midrst_a_count",     32'(a_count),     32'd0);
        check("midrst_b_out_valid", 32'(b_out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_idle_a_out_valid", 32'(a_out_valid), 32'd0);

        expect_beat(8'h10, 8'h10, 1, 1'b1);
        send_last(8'h10);

        repeat (3) @(posedge clk);
        #1;
        check("drain_q_a", 32'(q_a.size()), 32'd0);
        check("drain_q_b", 32'(q_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/minmax_tracker.md
Name: minmax_tracker

Overview:
- Streaming stage directly downstream of comparator: accepts a burst of unsigned operands over a valid/ready handshake and tracks the running minimum and maximum.
- Uses two comparator instances (WIDTH bits) as its decision logic.
- Presents min, max, sample count and an all-equal flag as one result beat when the burst ends.
- Feeds the ALU flag/result mux; stalls upstream while a result is pending.

Parameters:
- WIDTH, 8, operand width in bits; also the comparator SIZE.
- COUNT_W, 8, width of the sample counter; counter saturates at 2^COUNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  upstream has a sample.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  WIDTH  unsigned sample.
- in_last  input  1  sample is the final one of the burst.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- out_min  output  WIDTH  smallest sample of the burst.
- out_max  output  WIDTH  largest sample of the burst.
- out_count  output  COUNT_W  number of samples accepted, saturating.
- out_all_equal  output  1  every sample in the burst was identical.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n; all state is updated on the rising edge of clk.
- Reset (rst_n=0 at an edge): state=IDLE; min/max/count regs=0; out_valid=0; out_all_equal=0; in_ready=1 from the first cycle after reset.
- Accept = in_valid && in_ready. Result handoff = out_valid && out_ready.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - Accept with in_last=0 -> ACCUM; min=max=in_data, count=1.
    - Accept with in_last=1 -> HOLD; single-sample burst, min=max=in_data, count=1.
  - ACCUM: in_ready=1.
    - Each accept: max<=in_data if comparator(in_data,max).is_a_greater.
    - Each accept: min<=in_data if comparator(min,in_data).is_a_greater.
    - Each accept: count<=count+1, saturating at all-ones.
    - Accept with in_last=1 -> HOLD, with that sample included.
    - No accept -> stay; registers unchanged.
  - HOLD: in_ready=0; out_valid=1; outputs stable until handoff.
    - Handoff -> IDLE; in_ready=1 on the next cycle. No same-cycle re-accept.
- Latency: out_valid asserts the cycle after the last-sample accept.
- Output values:
  - out_all_equal = (min==max), using the comparator equal output, registered.
  - out_* are registered; values outside HOLD are don't-care for the checker but must not be X after reset.
- Comparisons are unsigned. Ties leave the registers unchanged, so no spurious update.
- Throughput: one sample per cycle in ACCUM; one idle cycle between bursts in HOLD->IDLE.
- in_valid deasserted mid-burst: stall with no state change.
- in_last sampled only on accept.
- Reset mid-burst or in HOLD: burst discarded; no result beat emitted.
- Counter saturation: count holds 2^COUNT_W-1; min/max keep updating.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic[1:0] {ST_IDLE, ST_ACCUM, ST_HOLD} mm_state_t.
  - localparam default WIDTH=8.
- Sub-module: the existing comparator, instantiated twice, named cmp_max and cmp_min.
- No other sub-modules.

Test Plan:
- Reset, then burst 0x12,0xF0,0x05(last) -> out_valid one cycle after 0x05 accept; min=0x05, max=0xF0, count=3, all_equal=0.
- Single sample 0x7A with in_last=1 from IDLE -> min=max=0x7A, count=1, all_equal=1.
- Burst 0x33,0x33,0x33(last) with out_ready held 0 for 4 cycles -> in_ready=0 and outputs stable throughout HOLD; handoff on out_ready=1; in_ready=1 the following cycle.
- Burst 0x80 then in_valid=0 for 3 cycles, then 0x00,0xFF(last) -> stalls ignored; min=0x00, max=0xFF, count=3.
- COUNT_W=2: burst of 5 samples 1,2,3,4,0(last) -> count=3 (saturated), min=0x00, max=0x04.
- rst_n=0 for one cycle after 2 samples of a burst -> no out_valid; next burst 0x10(last) reports min=max=0x10, count=1.
